// File: rtl/test_harness_seq_pkg.sv
// Shared types and defaults for the on-chip test sequencer.
package tb_harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    NEXT,
    DONE
  } harness_state_e;

  localparam int unsigned DEF_TIMEOUT_W      = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/test_harness_seq_next_index_finder.sv
// Finds the lowest set mask bit above (or at, when include_cur) the given index.
module next_index_finder
  import tb_harness_pkg::*;
#(
  parameter int unsigned NUM_TESTS = 4,
  parameter int unsigned IDX_W     = idx_width(NUM_TESTS)
) (
  input  logic [NUM_TESTS-1:0] mask,
  input  logic [IDX_W-1:0]     cur_idx,
  input  logic                 include_cur,
  output logic [IDX_W-1:0]     next_idx,
  output logic                 found
);

  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      if (!found && mask[i] &&
          ((i > 32'(cur_idx)) || (include_cur && (i == 32'(cur_idx))))) begin
        next_idx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/test_harness_seq.sv
// Test sequencer: launches each enabled channel in turn, waits for done or
// timeout, and accumulates pass/fail/timeout vectors.
module test_harness_seq
  import tb_harness_pkg::*;
#(
  parameter int unsigned NUM_TESTS      = 4,
  parameter int unsigned TIMEOUT_W      = DEF_TIMEOUT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter bit          STOP_ON_FAIL   = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               abort,
  input  logic [NUM_TESTS-1:0]               enable_mask,
  output logic [NUM_TESTS-1:0]               test_start,
  input  logic [NUM_TESTS-1:0]               test_done,
  input  logic [NUM_TESTS-1:0]               test_pass,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted,
  output logic [idx_width(NUM_TESTS)-1:0]    cur_idx,
  output logic [NUM_TESTS-1:0]               pass_vec,
  output logic [NUM_TESTS-1:0]               fail_vec,
  output logic [NUM_TESTS-1:0]               timeout_vec,
  output logic                               all_pass
);

  localparam int unsigned IDX_W = idx_width(NUM_TESTS);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  harness_state_e       state;
  logic [NUM_TESTS-1:0] mask_q;
  logic [TIMEOUT_W-1:0] timer;
  logic                 idle_or_done;
  logic [NUM_TESTS-1:0] find_mask;
  logic [IDX_W-1:0]     find_from;
  logic [IDX_W-1:0]     found_idx;
  logic                 found;

  // One finder serves both searches: from bit 0 of the incoming mask on start,
  // strictly past cur_idx of the latched mask in NEXT.
  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign find_mask    = idle_or_done ? enable_mask : mask_q;
  assign find_from    = idle_or_done ? '0 : cur_idx;

  next_index_finder #(
    .NUM_TESTS(NUM_TESTS),
    .IDX_W    (IDX_W)
  ) u_finder (
    .mask       (find_mask),
    .cur_idx    (find_from),
    .include_cur(idle_or_done),
    .next_idx   (found_idx),
    .found      (found)
  );

  always_comb begin
    test_start = '0;
    if (state == LAUNCH && !abort) test_start[cur_idx] = 1'b1;
  end

  assign busy     = (state == LAUNCH) || (state == WAIT) || (state == NEXT);
  assign all_pass = (state == DONE) && (pass_vec == mask_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mask_q      <= '0;
      timer       <= '0;
      cur_idx     <= '0;
      pass_vec    <= '0;
      fail_vec    <= '0;
      timeout_vec <= '0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              mask_q      <= enable_mask;
              pass_vec    <= '0;
              fail_vec    <= '0;
              timeout_vec <= '0;
              aborted     <= 1'b0;
              cur_idx     <= found_idx;
              if (found) begin
                state <= LAUNCH;
              end else begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          LAUNCH: begin
            timer <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (timer != '1) timer <= timer + TIMEOUT_W'(1);
            if (test_done[cur_idx]) begin
              if (test_pass[cur_idx]) pass_vec[cur_idx] <= 1'b1;
              else                    fail_vec[cur_idx] <= 1'b1;
              state <= NEXT;
            end else if (timer == TIMER_LAST) begin
              fail_vec[cur_idx]    <= 1'b1;
              timeout_vec[cur_idx] <= 1'b1;
              state                <= NEXT;
            end
          end
          NEXT: begin
            if (!found || (STOP_ON_FAIL && (fail_vec != '0))) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              cur_idx <= found_idx;
              state   <= LAUNCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_harness_seq.sv
// Scoreboard bench: two sequencers (STOP_ON_FAIL 0 and 1) with scripted channel responders.
module tb_test_harness_seq;

  localparam int T = 20;

  typedef struct { int idx; int cyc; } launch_t;
  typedef struct { logic [12:0] v; int cyc; } result_t;
  typedef struct { int u; int cyc; logic [21:0] v; } stat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_s [2];
  logic       abort_s [2];
  logic       busy    [2];
  logic       done_o  [2];
  logic       aborted [2];
  logic       all_pass[2];
  logic [3:0] mask_s  [2];
  logic [3:0] ts      [2];
  logic [3:0] td      [2];
  logic [3:0] tp      [2];
  logic [3:0] pass_v  [2];
  logic [3:0] fail_v  [2];
  logic [3:0] tout_v  [2];
  logic [1:0] idx     [2];

  int         dly     [2][4];
  logic [3:0] pv      [2];
  int         spur_cyc[2];

  launch_t exp_launch[2][$];
  result_t exp_res   [2][$];
  stat_t   stat_q[$];

  int total = 0;
  int bad   = 0;
  bit finished = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    test_harness_seq #(
      .NUM_TESTS     (4),
      .TIMEOUT_W     (16),
      .TIMEOUT_CYCLES(T),
      .STOP_ON_FAIL  (g == 1)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_s[g]),
      .abort      (abort_s[g]),
      .enable_mask(mask_s[g]),
      .test_start (ts[g]),
      .test_done  (td[g]),
      .test_pass  (tp[g]),
      .busy       (busy[g]),
      .done       (done_o[g]),
      .aborted    (aborted[g]),
      .cur_idx    (idx[g]),
      .pass_vec   (pass_v[g]),
      .fail_vec   (fail_v[g]),
      .timeout_vec(tout_v[g]),
      .all_pass   (all_pass[g])
    );
  end

  // Channel responders: answer dly cycles after the launch pulse (0 = never).
  initial begin : responder
    int cnt [2][4];
    logic [3:0] seen [2];
    for (int u = 0; u < 2; u++) begin
      td[u] = '0;
      tp[u] = '0;
      for (int i = 0; i < 4; i++) cnt[u][i] = -1;
    end
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) seen[u] = ts[u];
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        td[u] = '0;
        tp[u] = '0;
        for (int i = 0; i < 4; i++) begin
          if (seen[u][i]) cnt[u][i] = dly[u][i] - 1;
          else if (cnt[u][i] >= 0) cnt[u][i] = cnt[u][i] - 1;
          if (cnt[u][i] == 0) begin
            td[u][i] = 1'b1;
            tp[u][i] = pv[u][i];
          end
        end
        if (cyc == spur_cyc[u]) begin
          td[u][3] = 1'b1;
          tp[u][3] = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    launch_t l;
    result_t r;
    logic [3:0]  ev;
    logic [12:0] rv;
    logic [21:0] sv;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (ts[u] !== 4'b0) begin
          total++;
          if (exp_launch[u].size() == 0) begin
            bad++;
            $display("FAIL launch%0d: unexpected test_start=%b at cycle %0d", u, ts[u], cyc);
          end else begin
            l  = exp_launch[u].pop_front();
            ev = 4'(1 << l.idx);
            if (ts[u] !== ev || cyc != l.cyc) begin
              bad++;
              $display("FAIL launch%0d: got test_start=%b at cycle %0d, want %b at cycle %0d",
                       u, ts[u], cyc, ev, l.cyc);
            end
          end
        end
        if (done_o[u] !== 1'b0) begin
          total++;
          rv = {pass_v[u], fail_v[u], tout_v[u], all_pass[u]};
          if (exp_res[u].size() == 0) begin
            bad++;
            $display("FAIL done%0d: unexpected done at cycle %0d", u, cyc);
          end else begin
            r = exp_res[u].pop_front();
            if (rv !== r.v || aborted[u] !== 1'b0 || cyc != r.cyc) begin
              bad++;
              $display("FAIL done%0d: got pass/fail/tout/all_pass=%h aborted=%b at cycle %0d, want %h aborted=0 at cycle %0d",
                       u, rv, aborted[u], cyc, r.v, r.cyc);
            end
          end
        end
      end
      for (int k = stat_q.size() - 1; k >= 0; k--) begin
        if (stat_q[k].cyc <= cyc) begin
          total++;
          sv = {ts[stat_q[k].u], busy[stat_q[k].u], done_o[stat_q[k].u], aborted[stat_q[k].u],
                all_pass[stat_q[k].u], idx[stat_q[k].u], pass_v[stat_q[k].u],
                fail_v[stat_q[k].u], tout_v[stat_q[k].u]};
          if (stat_q[k].cyc != cyc || sv !== stat_q[k].v) begin
            bad++;
            $display("FAIL status%0d: got %h at cycle %0d, want %h at cycle %0d",
                     stat_q[k].u, sv, cyc, stat_q[k].v, stat_q[k].cyc);
          end
          stat_q.delete(k);
        end
      end
      if (finished) begin
        for (int u = 0; u < 2; u++) begin
          total++;
          if (exp_launch[u].size() != 0 || exp_res[u].size() != 0) begin
            bad++;
            $display("FAIL drain%0d: got %0d launches and %0d results outstanding, want 0 and 0",
                     u, exp_launch[u].size(), exp_res[u].size());
          end
        end
        total++;
        if (stat_q.size() != 0) begin
          bad++;
          $display("FAIL status_drain: got %0d checks outstanding, want 0", stat_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // Reference model: each test occupies LAUNCH + k WAIT cycles + NEXT.
  task automatic run(input int u, input logic [3:0] m, input int d0, input int d1,
                     input int d2, input int d3, input logic [3:0] p_in,
                     input int abort_off, input int hold, input int spur_off);
    int d [4];
    int c, t, keff, lidx;
    logic [3:0] p, f, to;
    bit stop_run;
    d = '{d0, d1, d2, d3};
    @(posedge clk);
    #1;
    c = cyc;
    dly[u] = d;
    pv[u] = p_in;
    spur_cyc[u] = (spur_off > 0) ? c + spur_off : -1;
    p = '0; f = '0; to = '0; t = c + 1; stop_run = 1'b0; lidx = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && !stop_run) begin
        keff = (d[i] > 0 && d[i] <= T) ? d[i] : T;
        if (abort_off == 0 || t < c + abort_off) begin
          exp_launch[u].push_back('{i, t});
          lidx = i;
        end
        if (abort_off == 0 || t + keff < c + abort_off) begin
          if (d[i] > 0 && d[i] <= T) begin
            if (p_in[i]) p[i] = 1'b1;
            else         f[i] = 1'b1;
          end else begin
            f[i] = 1'b1;
            to[i] = 1'b1;
          end
        end
        t = t + keff + 2;
        if (u == 1 && f != 4'b0) stop_run = 1'b1;
      end
    end
    if (abort_off == 0)
      exp_res[u].push_back('{{p, f, to, (p == m)}, t});
    else
      stat_q.push_back('{u, c + abort_off + 1,
                         {4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'(lidx), p, f, to}});
    mask_s[u]  = m;
    start_s[u] = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    start_s[u] = 1'b0;
    mask_s[u]  = ~m;
    if (abort_off > 0) begin
      while (cyc < c + abort_off) begin
        @(posedge clk);
        #1;
      end
      abort_s[u] = 1'b1;
      @(posedge clk);
      #1;
      abort_s[u] = 1'b0;
      repeat (8) @(posedge clk);
    end else begin
      for (int n = 0; n < 300; n++) begin
        @(negedge clk);
        if (done_o[u]) break;
      end
      repeat (3) @(posedge clk);
    end
  endtask

  initial begin : stim
    int c;
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0;
      abort_s[u] = 1'b0;
      mask_s[u]  = '0;
      pv[u]      = '0;
      spur_cyc[u] = -1;
      for (int i = 0; i < 4; i++) dly[u][i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    stat_q.push_back('{0, cyc, 22'd0});
    stat_q.push_back('{1, cyc, 22'd0});
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(0, 4'b1111, 5, 5, 5, 5, 4'b1111, 0, 1, 0);  // all pass
    run(0, 4'b0101, 5, 5, 5, 5, 4'b1011, 0, 1, 0);  // ch2 fails, ch1/ch3 skipped
    run(0, 4'b1111, 5, 0, 5, 5, 4'b1111, 0, 1, 0);  // ch1 times out
    run(0, 4'b0000, 5, 5, 5, 5, 4'b1111, 0, 1, 0);  // empty mask
    run(0, 4'b1001, 8, 5, 5, 5, 4'b1111, 0, 1, 3);  // stray done on ch3 during ch0
    run(0, 4'b0010, 5, T, 5, 5, 4'b1111, 0, 1, 0);  // done on the timeout cycle
    run(0, 4'b0110, 5, 5, 5, 5, 4'b1111, 0, 6, 0);  // start held during run
    run(0, 4'b1111, 5, 5, 5, 5, 4'b1111, 18, 1, 0); // abort in ch2 WAIT
    run(0, 4'b0000, 5, 5, 5, 5, 4'b1111, 0, 1, 0);  // restart clears aborted/vectors
    run(1, 4'b1111, 5, 5, 5, 5, 4'b1101, 0, 1, 0);  // stop after ch1 fail
    run(1, 4'b1100, 5, 5, 0, 5, 4'b1111, 0, 1, 0);  // stop after ch2 timeout
    run(1, 4'b0101, 5, 5, 5, 5, 4'b1111, 0, 1, 0);  // no failure, runs through

    // Asynchronous reset during ch1 WAIT.
    @(posedge clk);
    #1;
    c = cyc;
    dly[0] = '{5, 5, 5, 5};
    pv[0]  = 4'b1111;
    spur_cyc[0] = -1;
    exp_launch[0].push_back('{0, c + 1});
    exp_launch[0].push_back('{1, c + 8});
    mask_s[0]  = 4'b0011;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    while (cyc < c + 10) begin
      @(posedge clk);
      #1;
    end
    stat_q.push_back('{0, cyc, 22'd0});
    stat_q.push_back('{1, cyc, 22'd0});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    finished = 1'b1;
  end

endmodule
